// File: rtl/craft_pkg.sv
// Shared constants and helpers for the CRAFT tweakey / round-constant scheduler.
// Reverse-order seeds are only consumed when CRAFT_KS_DEC_EN is defined.
package craft_pkg;

    localparam int TK_W  = 64;
    localparam int KEY_W = 128;
    localparam int RC_W  = 8;

    localparam logic [3:0] LFSR_A_SEED  = 4'h1;
    localparam logic [2:0] LFSR_B_SEED  = 3'h1;
    localparam logic [3:0] LFSR_A_REV32 = 4'h8;
    localparam logic [2:0] LFSR_B_REV32 = 3'h5;

    // QT nibble j takes T nibble Q_PERM[j]; nibble 0 is the most significant.
    localparam logic [3:0] Q_PERM [16] = '{4'd12, 4'd10, 4'd15, 4'd5, 4'd14, 4'd8, 4'd9, 4'd2,
                                           4'd11, 4'd3, 4'd7, 4'd4, 4'd6, 4'd0, 4'd1, 4'd13};

    typedef enum logic {ST_IDLE, ST_RUN} ks_state_e;

    function automatic logic [TK_W-1:0] q_permute(input logic [TK_W-1:0] t);
        logic [TK_W-1:0] qt;
        qt = '0;
        for (int j = 0; j < 16; j++) begin
            qt[63-4*j -: 4] = t[63-4*int'(Q_PERM[j]) -: 4];
        end
        return qt;
    endfunction

    function automatic logic [3:0] a_fwd(input logic [3:0] a);
        return {a[0] ^ a[1], a[3:1]};
    endfunction

    function automatic logic [3:0] a_rev(input logic [3:0] a);
        return {a[2:0], a[3] ^ a[0]};
    endfunction

    function automatic logic [2:0] b_fwd(input logic [2:0] b);
        return {b[0] ^ b[1], b[2:1]};
    endfunction

    function automatic logic [2:0] b_rev(input logic [2:0] b);
        return {b[1:0], b[2] ^ b[0]};
    endfunction

    // LFSR pair state {a, b} after n forward steps from the reset seeds.
    function automatic logic [6:0] rc_state_at(input int n);
        logic [3:0] a;
        logic [2:0] b;
        a = LFSR_A_SEED;
        b = LFSR_B_SEED;
        for (int i = 0; i < n; i++) begin
            a = a_fwd(a);
            b = b_fwd(b);
        end
        return {a, b};
    endfunction

    function automatic logic [TK_W-1:0] tk_select(input logic [1:0] sel,
                                                  input logic [TK_W-1:0] k0,
                                                  input logic [TK_W-1:0] k1,
                                                  input logic [TK_W-1:0] t,
                                                  input logic [TK_W-1:0] qt);
        case (sel)
            2'd0:    return k0 ^ t;
            2'd1:    return k1 ^ t;
            2'd2:    return k0 ^ qt;
            default: return k1 ^ qt;
        endcase
    endfunction

endpackage

// File: rtl/craft_rc_lfsr.sv
// Round-constant LFSR pair (4-bit a, 3-bit b) with seed load, forward step and reverse step.
// Exposes the value the pair will hold after this cycle so the parent can register RC alongside it.
module craft_rc_lfsr
    import craft_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       step_i,
    input  logic       rev_i,
    input  logic [3:0] seed_a_i,
    input  logic [2:0] seed_b_i,
    output logic [3:0] a_nxt_o,
    output logic [2:0] b_nxt_o
);

    logic [3:0] a_q, a_d;
    logic [2:0] b_q, b_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_i) begin
            a_d = seed_a_i;
            b_d = seed_b_i;
        end else if (step_i) begin
            a_d = rev_i ? a_rev(a_q) : a_fwd(a_q);
            b_d = rev_i ? b_rev(b_q) : b_fwd(b_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= LFSR_A_SEED;
            b_q <= LFSR_B_SEED;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_nxt_o = a_d;
    assign b_nxt_o = b_d;

endmodule

// File: rtl/craft_tweakey_sched.sv
// CRAFT round tweakey / round-constant sequencer: latches key and tweak on start, steps one round per advance.
// Defining CRAFT_KS_DEC_EN adds the dir input for reverse (decryption) round order.
module craft_tweakey_sched
    import craft_pkg::*;
#(
    parameter int NUM_ROUNDS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic [TK_W-1:0]  tweak,
`ifdef CRAFT_KS_DEC_EN
    input  logic             dir,
`endif
    input  logic             advance,
    output logic [TK_W-1:0]  round_tk,
    output logic [RC_W-1:0]  round_const,
    output logic [4:0]       round_idx,
    output logic             valid,
    output logic             last
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - 1);

    ks_state_e        state_q, state_d;
    logic [TK_W-1:0]  k0_q, k0_d, k1_q, k1_d, t_q, t_d, qt_q, qt_d;
    logic [TK_W-1:0]  tk_q, tk_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [4:0]       idx_q, idx_d;
    logic             valid_q, valid_d, last_q, last_d;
    logic             lfsr_load, lfsr_step;
    logic             rev_q, rev_d;
    logic [3:0]       seed_a, a_nxt;
    logic [2:0]       seed_b, b_nxt;

`ifdef CRAFT_KS_DEC_EN
    localparam logic [6:0] REV_STATE = (NUM_ROUNDS == 32) ? {LFSR_A_REV32, LFSR_B_REV32}
                                                         : rc_state_at(NUM_ROUNDS - 1);

    assign rev_d  = start ? dir : rev_q;
    assign seed_a = rev_d ? REV_STATE[6:3] : LFSR_A_SEED;
    assign seed_b = rev_d ? REV_STATE[2:0] : LFSR_B_SEED;

    always_ff @(posedge clk) begin
        if (!rst_n) rev_q <= 1'b0;
        else        rev_q <= rev_d;
    end
`else
    assign rev_q  = 1'b0;
    assign rev_d  = 1'b0;
    assign seed_a = LFSR_A_SEED;
    assign seed_b = LFSR_B_SEED;
`endif

    // Kept apart from the main next-state block so the LFSR's look-ahead output never loops back into it.
    always_comb begin
        lfsr_load = start;
        lfsr_step = !start && advance && (state_q == ST_RUN) && !last_q;
    end

    craft_rc_lfsr u_rc_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (lfsr_load),
        .step_i   (lfsr_step),
        .rev_i    (rev_q),
        .seed_a_i (seed_a),
        .seed_b_i (seed_b),
        .a_nxt_o  (a_nxt),
        .b_nxt_o  (b_nxt)
    );

    always_comb begin
        state_d = state_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        t_d     = t_q;
        qt_d    = qt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        tk_d    = tk_q;
        rc_d    = rc_q;
        if (start) begin
            k0_d    = key[KEY_W-1:TK_W];
            k1_d    = key[TK_W-1:0];
            t_d     = tweak;
            qt_d    = q_permute(tweak);
            state_d = ST_RUN;
            valid_d = 1'b1;
            idx_d   = rev_d ? LAST_IDX : 5'd0;
        end else if (advance && (state_q == ST_RUN)) begin
            if (last_q) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end else begin
                idx_d = rev_q ? idx_q - 5'd1 : idx_q + 5'd1;
            end
        end
        // Final-round values stay on the outputs after the run ends.
        if (lfsr_load || lfsr_step) begin
            tk_d = tk_select(idx_d[1:0], k0_d, k1_d, t_d, qt_d);
            rc_d = {a_nxt, 1'b0, b_nxt};
        end
        last_d = valid_d && (idx_d == (rev_d ? 5'd0 : LAST_IDX));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k0_q    <= '0;
            k1_q    <= '0;
            t_q     <= '0;
            qt_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            tk_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            t_q     <= t_d;
            qt_q    <= qt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            tk_q    <= tk_d;
            rc_q    <= rc_d;
        end
    end

    assign round_tk    = tk_q;
    assign round_const = rc_q;
    assign round_idx   = idx_q;
    assign valid       = valid_q;
    assign last        = last_q;

endmodule

// File: tb/tb_craft_tweakey_sched.sv
// Scoreboard bench for craft_tweakey_sched: the driver pushes the expected output word per cycle,
// the monitor pops and compares one cycle later. Reverse-order checks run when CRAFT_KS_DEC_EN is defined.
module tb_craft_tweakey_sched;

    localparam int N = 32;
    localparam int W = 79;

    localparam logic [127:0] KEY   = 128'h27a6781a43f364bc916708d5fbb5aefe;
    localparam logic [63:0]  TWEAK = 64'h54CD94FFD0670A58;

    // Hand-computed round tweakeys for KEY/TWEAK: K0^T, K1^T, K0^QT, K1^QT.
    logic [63:0] tk_tab [4] = '{64'h736BECE593946EE4, 64'hC5AA9C2A2BD2A4A6,
                                64'h212225163E0A91F6, 64'h97E355D9864C5BB4};
    logic [7:0]  rc_tab [8] = '{8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hc7, 8'h63, 8'hb1};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         advance = 1'b0;
    logic [127:0] key = '0;
    logic [63:0]  tweak = '0;
`ifdef CRAFT_KS_DEC_EN
    logic         dir = 1'b0;
`endif
    logic [63:0]  round_tk;
    logic [7:0]   round_const;
    logic [4:0]   round_idx;
    logic         valid;
    logic         last;

    always #5 clk = ~clk;

    craft_tweakey_sched #(.NUM_ROUNDS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key         (key),
        .tweak       (tweak),
`ifdef CRAFT_KS_DEC_EN
        .dir         (dir),
`endif
        .advance     (advance),
        .round_tk    (round_tk),
        .round_const (round_const),
        .round_idx   (round_idx),
        .valid       (valid),
        .last        (last)
    );

    logic [W-1:0] exp_q [$];
    string        tag_q [$];
    int           tests_run = 0;
    int           tests_failed = 0;

    bit          dir_sel = 1'b0;
    bit          m_run, m_last, m_dir;
    int          m_idx;
    logic [3:0]  m_a;
    logic [2:0]  m_b;
    logic [63:0] m_tk;
    logic [7:0]  m_rc;

    task automatic model_present();
        m_tk = tk_tab[m_idx % 4];
        if (m_idx < 8)           m_rc = rc_tab[m_idx];
        else if (m_idx == N - 1) m_rc = 8'h85;
        else                     m_rc = {m_a, 1'b0, m_b};
        m_last = (m_idx == (m_dir ? 0 : N - 1));
    endtask

    task automatic step(input bit st, input bit adv, input bit rst, input string name);
        @(negedge clk);
        rst_n   = ~rst;
        start   = st;
        advance = adv;
        if (st) begin
            key   = KEY;
            tweak = TWEAK;
        end else begin
            key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            tweak = {$urandom(), $urandom()};
        end
`ifdef CRAFT_KS_DEC_EN
        dir = st ? dir_sel : 1'($urandom_range(0, 1));
`endif
        if (rst) begin
            m_run = 0; m_last = 0; m_dir = 0; m_idx = 0;
            m_a = 4'h1; m_b = 3'h1; m_tk = '0; m_rc = '0;
        end else if (st) begin
            m_run = 1;
            m_dir = dir_sel;
            m_idx = m_dir ? N - 1 : 0;
            m_a   = m_dir ? 4'h8 : 4'h1;
            m_b   = m_dir ? 3'h5 : 3'h1;
            model_present();
        end else if (adv && m_run) begin
            if (m_last) begin
                m_run  = 0;
                m_last = 0;
            end else if (m_dir) begin
                m_idx = m_idx - 1;
                m_a = {m_a[2:0], m_a[3] ^ m_a[0]};
                m_b = {m_b[1:0], m_b[2] ^ m_b[0]};
                model_present();
            end else begin
                m_idx = m_idx + 1;
                m_a = {m_a[0] ^ m_a[1], m_a[3:1]};
                m_b = {m_b[0] ^ m_b[1], m_b[2:1]};
                model_present();
            end
        end
        exp_q.push_back({m_run, m_last, 5'(m_idx), m_tk, m_rc});
        tag_q.push_back(name);
    endtask

    initial begin : monitor
        logic [W-1:0] e, g;
        string        t;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                g = {valid, last, round_idx, round_tk, round_const};
                tests_run++;
                if (g !== e) begin
                    tests_failed++;
                    $display("FAIL %s: got v=%0b l=%0b idx=%0d tk=%h rc=%h, expected v=%0b l=%0b idx=%0d tk=%h rc=%h",
                             t, g[78], g[77], g[76:72], g[71:8], g[7:0],
                             e[78], e[77], e[76:72], e[71:8], e[7:0]);
                end
            end
        end
    end

    initial begin : driver
        step(0, 0, 1, "reset");
        step(0, 1, 1, "reset_adv");

        step(1, 0, 0, "load_round0");
        for (int i = 0; i < N - 1; i++) step(0, 1, 0, "fwd_advance");
        step(0, 1, 0, "finish_to_idle");
        for (int i = 0; i < 3; i++) step(0, 1, 0, "idle_advance");
        step(0, 0, 0, "idle_hold");

        step(1, 0, 0, "reload");
        for (int i = 0; i < 10; i++) step(0, 1, 0, "to_round10");
        step(0, 0, 0, "stall_round10");
        step(1, 0, 0, "restart_round10");
        step(0, 1, 0, "adv_after_restart");
        step(1, 1, 0, "start_and_advance");
        step(0, 0, 0, "hold_round0");

        for (int i = 0; i < 5; i++) step(0, 1, 0, "to_round5");
        step(0, 1, 1, "reset_midrun");
        step(0, 1, 0, "adv_after_reset");

`ifdef CRAFT_KS_DEC_EN
        dir_sel = 1'b1;
        step(1, 0, 0, "rev_load");
        for (int i = 0; i < N - 1; i++) step(0, 1, 0, "rev_advance");
        step(0, 1, 0, "rev_to_idle");
        dir_sel = 1'b0;
        step(1, 0, 0, "fwd_after_rev");
        step(0, 1, 0, "fwd_after_rev_adv");
`endif

        @(negedge clk);
        start   = 1'b0;
        advance = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
